fir_decim_buf: RTL and testbench

- Downstream stage of the 5-tap FIR filter. It consumes the FIR's 32-bit output stream.
- Decimates the stream by DECIM by summing DECIM accepted samples, then scales the sum by a right shift and saturates it to OUT_W bits.
- Buffers the results in a DEPTH-entry FIFO with a valid/ready output interface, so slower consumers can read the filtered, decimated stream.
- Results that cannot be stored because the FIFO is full are dropped and counted.

---
 rtl/fir_decim_buf.sv | 204 ++++++++++++++++++++
 tb/tb_fir_decim_buf.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_buf.sv
// ---------------------------------------------------------------------------
// fir_decim_buf
//
// Downstream stage of the 5-tap FIR. Sums DECIM accepted 32-bit samples,
// scales the sum by a right shift of SHIFT, saturates it to OUT_W unsigned
// bits and pushes the result into a DEPTH-entry FIFO read through a
// valid/ready interface. Results that find the FIFO full (with no
// simultaneous pop) are dropped and counted.
//
// Ports:
//   clk        : clock, all state updates on the rising edge
//   rst        : synchronous active-high reset, overrides every other input
//   in_valid   : in_data carries a FIR sample this cycle
//   in_data    : 32-bit unsigned FIR output sample
//   out_valid  : FIFO head is available (level > 0)
//   out_ready  : consumer takes the head this cycle
//   out_data   : FIFO head value, registered, stable while not popped
//   level      : FIFO occupancy 0..DEPTH
//   overflow   : sticky flag, at least one result was dropped
//   drop_count : saturating count of dropped results
//   ovf_clr    : clears overflow and drop_count (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module fir_decim_buf #(
   parameter int DECIM = 4,
   parameter int SHIFT = 5,
   parameter int OUT_W = 8,
   parameter int DEPTH = 8,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [31:0]                in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           out_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   output logic [CNT_W-1:0]           drop_count,
   input  logic                       ovf_clr
);

   // Accumulator is wide enough to hold DECIM full-scale samples without wrap.
   localparam int ACC_W = 32 + $clog2(DECIM) + 1;
   localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [ACC_W-1:0] RES_MAX   = ACC_W'({OUT_W{1'b1}});
   localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(DECIM - 1);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   // Decimator state
   logic [PH_W-1:0]  phase_q, phase_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [OUT_W-1:0] res_q, res_d;
   logic             res_v_q, res_v_d;

   // FIFO state
   logic [OUT_W-1:0] mem_q [DEPTH];
   logic [OUT_W-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;

   // Overflow bookkeeping
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] drop_count_q, drop_count_d;

   // Combinational helpers
   logic [ACC_W-1:0] sum_s;
   logic [ACC_W-1:0] scaled_s;
   logic             full_s;
   logic             pop_s;
   logic             push_s;
   logic             drop_s;

   // Next-state logic for decimator, FIFO and drop accounting.
   always_comb begin
      phase_d      = phase_q;
      acc_d        = acc_q;
      res_d        = res_q;
      res_v_d      = 1'b0;
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      overflow_d   = overflow_q;
      drop_count_d = drop_count_q;

      sum_s    = acc_q + {{(ACC_W-32){1'b0}}, in_data};
      scaled_s = sum_s >> SHIFT;

      // Decimation: gaps in in_valid leave phase and acc untouched.
      if (in_valid) begin
         if (phase_q == PH_LAST) begin
            if (scaled_s > RES_MAX) begin
               res_d = {OUT_W{1'b1}};
            end else begin
               res_d = scaled_s[OUT_W-1:0];
            end
            res_v_d = 1'b1;
            acc_d   = {ACC_W{1'b0}};
            phase_d = {PH_W{1'b0}};
         end else begin
            acc_d   = sum_s;
            phase_d = phase_q + PH_W'(1);
         end
      end else begin
         phase_d = phase_q;
      end

      // A full FIFO still accepts a push when the head leaves the same cycle.
      full_s = (level_q == LVL_FULL);
      pop_s  = out_valid_q & out_ready;
      push_s = res_v_q & (~full_s | pop_s);
      drop_s = res_v_q & full_s & ~pop_s;

      if (push_s) begin
         mem_d[wr_ptr_q] = res_q;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      if (push_s && !pop_s) begin
         level_d = level_q + LVL_W'(1);
      end else if (pop_s && !push_s) begin
         level_d = level_q - LVL_W'(1);
      end else begin
         level_d = level_q;
      end

      // Head is read from the post-write image so a push into an empty
      // (or simultaneously drained) FIFO is visible the next cycle.
      out_valid_d = (level_d != {LVL_W{1'b0}});
      out_data_d  = mem_d[rd_ptr_d];

      // A drop in the clearing cycle takes precedence over the clear.
      if (drop_s) begin
         overflow_d = 1'b1;
         if (ovf_clr) begin
            drop_count_d = CNT_W'(1);
         end else if (drop_count_q != CNT_MAX) begin
            drop_count_d = drop_count_q + CNT_W'(1);
         end else begin
            drop_count_d = drop_count_q;
         end
      end else if (ovf_clr) begin
         overflow_d   = 1'b0;
         drop_count_d = {CNT_W{1'b0}};
      end else begin
         overflow_d   = overflow_q;
         drop_count_d = drop_count_q;
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q      <= {PH_W{1'b0}};
         acc_q        <= {ACC_W{1'b0}};
         res_q        <= {OUT_W{1'b0}};
         res_v_q      <= 1'b0;
         mem_q        <= '{default: '0};
         wr_ptr_q     <= {PTR_W{1'b0}};
         rd_ptr_q     <= {PTR_W{1'b0}};
         level_q      <= {LVL_W{1'b0}};
         out_valid_q  <= 1'b0;
         out_data_q   <= {OUT_W{1'b0}};
         overflow_q   <= 1'b0;
         drop_count_q <= {CNT_W{1'b0}};
      end else begin
         phase_q      <= phase_d;
         acc_q        <= acc_d;
         res_q        <= res_d;
         res_v_q      <= res_v_d;
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign level      = level_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule

// File: tb/tb_fir_decim_buf.sv
// ---------------------------------------------------------------------------
// tb_fir_decim_buf
//
// Directed bench for fir_decim_buf with default parameters (DECIM=4,
// SHIFT=5, OUT_W=8, DEPTH=8, CNT_W=16). Inputs change 1 time unit after a
// rising edge and outputs are sampled at that same point, so each check
// sees the state produced by the preceding edge.
// ---------------------------------------------------------------------------
module tb_fir_decim_buf;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_data;
   logic [3:0]  level;
   logic        overflow;
   logic [15:0] drop_count;
   logic        ovf_clr;

   int total;
   int bad;

   fir_decim_buf dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .level      (level),
      .overflow   (overflow),
      .drop_count (drop_count),
      .ovf_clr    (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One valid sample for one cycle, then in_valid drops.
   task automatic send(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      tick();
      in_valid = 1'b0;
      in_data  = 32'd0;
   endtask

   task automatic send_group(input logic [31:0] d);
      for (int i = 0; i < 4; i++) send(d);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %0d want 0", out_valid); end
      total++; if (out_data !== 8'd0) begin bad++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
      total++; if (level !== 4'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0d want 0", overflow); end
      total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL reset_drop_count: got %0d want 0", drop_count); end
   endtask

   task automatic test_basic();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(32'd100);
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid[%0d]: got %0d want 0", i, out_valid); end
      end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid: got %0d want 1", out_valid); end
      total++; if (out_data !== 8'd12) begin bad++; $display("FAIL basic_data: got %0d want 12", out_data); end
      total++; if (level !== 4'd1) begin bad++; $display("FAIL basic_level: got %0d want 1", level); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_one_cycle: got %0d want 0", out_valid); end
      total++; if (level !== 4'd0) begin bad++; $display("FAIL basic_level_after: got %0d want 0", level); end
   endtask

   task automatic test_gaps();
      int gaps [3] = '{0, 2, 3};
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         send(32'd100);
         for (int g = 0; g < gaps[i]; g++) begin
            tick();
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gaps_early_valid[%0d.%0d]: got %0d want 0", i, g, out_valid); end
         end
      end
      send(32'd100);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gaps_res_stage: got %0d want 0", out_valid); end
      tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL gaps_valid: got %0d want 1", out_valid); end
      total++; if (out_data !== 8'd12) begin bad++; $display("FAIL gaps_data: got %0d want 12", out_data); end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gaps_single: got %0d want 0", out_valid); end
   endtask

   task automatic test_saturation();
      out_ready = 1'b0;
      send_group(32'hFFFF_FFFF);
      tick();
      total++; if (out_data !== 8'd255) begin bad++; $display("FAIL sat_high: got %0d want 255", out_data); end
      send_group(32'd0);
      tick();
      total++; if (level !== 4'd2) begin bad++; $display("FAIL sat_level: got %0d want 2", level); end
      total++; if (out_data !== 8'd255) begin bad++; $display("FAIL sat_hold: got %0d want 255", out_data); end
      out_ready = 1'b1;
      tick();
      total++; if (out_data !== 8'd0) begin bad++; $display("FAIL sat_zero: got %0d want 0", out_data); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sat_zero_valid: got %0d want 1", out_valid); end
      tick();
      total++; if (level !== 4'd0) begin bad++; $display("FAIL sat_drained: got %0d want 0", level); end
   endtask

   task automatic test_overflow();
      out_ready = 1'b0;
      for (int k = 1; k <= 10; k++) send_group(32'(32 * k));
      tick();
      tick();
      total++; if (level !== 4'd8) begin bad++; $display("FAIL ovf_level: got %0d want 8", level); end
      total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag: got %0d want 1", overflow); end
      total++; if (drop_count !== 16'd2) begin bad++; $display("FAIL ovf_drop_count: got %0d want 2", drop_count); end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL ovf_drain_valid[%0d]: got %0d want 1", i, out_valid); end
         total++; if (out_data !== 8'(4 * (i + 1))) begin bad++; $display("FAIL ovf_drain_data[%0d]: got %0d want %0d", i, out_data, 4 * (i + 1)); end
         tick();
      end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ovf_drained: got %0d want 0", out_valid); end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr_flag: got %0d want 0", overflow); end
      total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL ovf_clr_count: got %0d want 0", drop_count); end
   endtask

   task automatic test_full_pop();
      out_ready = 1'b0;
      for (int k = 11; k <= 18; k++) send_group(32'(32 * k));
      tick();
      total++; if (level !== 4'd8) begin bad++; $display("FAIL fullpop_level_pre: got %0d want 8", level); end
      send_group(32'(32 * 19));
      // result register holds 76 now; pop in the same cycle it pushes
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      total++; if (level !== 4'd8) begin bad++; $display("FAIL fullpop_level: got %0d want 8", level); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fullpop_overflow: got %0d want 0", overflow); end
      total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL fullpop_drop: got %0d want 0", drop_count); end
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         int exp_v;
         exp_v = (i < 7) ? 48 + 4 * i : 76;
         total++; if (out_data !== 8'(exp_v)) begin bad++; $display("FAIL fullpop_order[%0d]: got %0d want %0d", i, out_data, exp_v); end
         tick();
      end
      total++; if (level !== 4'd0) begin bad++; $display("FAIL fullpop_drained: got %0d want 0", level); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      for (int k = 0; k < 9; k++) send_group(32'd32);
      tick();
      total++; if (drop_count !== 16'd1) begin bad++; $display("FAIL rmid_pre_drop: got %0d want 1", drop_count); end
      send(32'd100);
      send(32'd100);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid: got %0d want 0", out_valid); end
      total++; if (out_data !== 8'd0) begin bad++; $display("FAIL rmid_out_data: got %0d want 0", out_data); end
      total++; if (level !== 4'd0) begin bad++; $display("FAIL rmid_level: got %0d want 0", level); end
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rmid_overflow: got %0d want 0", overflow); end
      total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL rmid_drop_count: got %0d want 0", drop_count); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(32'd64);
         tick();
         if (i < 3) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_early[%0d]: got %0d want 0", i, out_valid); end
         end else begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_valid: got %0d want 1", out_valid); end
            total++; if (out_data !== 8'd8) begin bad++; $display("FAIL rmid_data: got %0d want 8", out_data); end
         end
      end
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_single: got %0d want 0", out_valid); end
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      out_ready = 1'b0;
      ovf_clr   = 1'b0;
      #1;
      test_reset();
      test_basic();
      test_gaps();
      test_saturation();
      test_overflow();
      test_full_pop();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
